decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_pkg.sv | 58 +++++
 rtl/decoder_comb.sv | 94 +++++++++
 rtl/decoder.sv | 73 +++++++
 tb/tb_decoder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared MIPS decode constants: opcode/funct/REGIMM encodings, the
// immediate-extension select, and the packed decode-result record.
// EXT, CMP and NPC import this package so they agree on these values.
package decoder_pkg;

    // Primary opcodes, IR[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // SPECIAL funct codes, IR[5:0]
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    // REGIMM sub-opcodes carried in the rt field
    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    // Register written by jal
    localparam logic [4:0] REG_RA = 5'd31;

    // Immediate-extension select; 2'b11 is unused
    typedef enum logic [1:0] {
        ZERO_EXT = 2'b00,
        SIGN_EXT = 2'b01,
        HIGH_EXT = 2'b10
    } ext_op_e;

    // Complete decode result for one instruction
    typedef struct packed {
        ext_op_e    ext_op;
        logic       beq;
        logic       bne;
        logic       bltz;
        logic       blez;
        logic       bgtz;
        logic       bgez;
        logic       isb;
        logic       isj;
        logic       isjr;
        logic       reg_write;
        logic       mem_write;
        logic [4:0] a3;
        logic       illegal;
    } decode_t;

endpackage

// File: rtl/decoder_comb.sv
// Purely combinational MIPS instruction decode. Produces the full decode
// record from the instruction word; unsupported encodings yield a record
// with only the illegal flag set.
module decoder_comb
    import decoder_pkg::*;
(
    input  logic [31:0] ir_i,
    output decode_t     dec_o
);

    logic [5:0] opcode;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    logic       bad;
    decode_t    dec;

    assign opcode = ir_i[31:26];
    assign rt     = ir_i[20:16];
    assign rd     = ir_i[15:11];
    assign funct  = ir_i[5:0];

    // Decode opcode/funct into control flags, extension select and destination
    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path can leave a value unassigned and infer a latch.
        dec = '0;
        bad = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU, FN_SUBU: begin
                        dec.reg_write = 1'b1;
                        dec.a3        = rd;
                    end
                    FN_JR:   dec.isjr = 1'b1;
                    // Only the all-zero word (sll $0,$0,0) is accepted as nop
                    default: bad = (ir_i != 32'd0);
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ: dec.bltz = 1'b1;
                    RT_BGEZ: dec.bgez = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            OP_BEQ:  dec.beq  = 1'b1;
            OP_BNE:  dec.bne  = 1'b1;
            OP_BLEZ: dec.blez = 1'b1;
            OP_BGTZ: dec.bgtz = 1'b1;
            OP_J:    dec.isj  = 1'b1;
            OP_JAL: begin
                dec.isj       = 1'b1;
                dec.reg_write = 1'b1;
                dec.a3        = REG_RA;
            end
            OP_ORI: begin
                dec.reg_write = 1'b1;
                dec.a3        = rt;
            end
            OP_LUI: begin
                dec.ext_op    = HIGH_EXT;
                dec.reg_write = 1'b1;
                dec.a3        = rt;
            end
            OP_ADDIU, OP_LW: begin
                dec.ext_op    = SIGN_EXT;
                dec.reg_write = 1'b1;
                dec.a3        = rt;
            end
            OP_SW: begin
                dec.ext_op    = SIGN_EXT;
                dec.mem_write = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        // All branches sign-extend their offset
        dec.isb = dec.beq | dec.bne | dec.bltz | dec.blez | dec.bgtz | dec.bgez;
        if (dec.isb) begin
            dec.ext_op = SIGN_EXT;
        end

        // An illegal encoding suppresses every other output
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign dec_o = dec;

endmodule

// File: rtl/decoder.sv
// MIPS instruction decoder top. Wraps decoder_comb and optionally adds one
// register stage on all outputs.
// Build option: define DECODER_PIPE_EN to register the outputs (one-cycle
// latency, asynchronous active-low clear); otherwise outputs are purely
// combinational and clk/reset are unused.
module decoder
    import decoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    output logic [1:0]  EXTop,
    output logic        beq,
    output logic        bne,
    output logic        bltz,
    output logic        blez,
    output logic        bgtz,
    output logic        bgez,
    output logic        isb,
    output logic        isj,
    output logic        isjr,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [4:0]  A3,
    output logic        illegal
);

    decode_t dec_d;
    decode_t dec_out;

    decoder_comb u_comb (
        .ir_i  (IR),
        .dec_o (dec_d)
    );

`ifdef DECODER_PIPE_EN
    decode_t dec_q;

    // Output register stage, cleared asynchronously while reset is low
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples its input from before the edge.
        if (!reset) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign dec_out = dec_q;
`else
    // Combinational build: clock and reset are intentionally unused
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign dec_out = dec_d;
`endif

    assign EXTop    = dec_out.ext_op;
    assign beq      = dec_out.beq;
    assign bne      = dec_out.bne;
    assign bltz     = dec_out.bltz;
    assign blez     = dec_out.blez;
    assign bgtz     = dec_out.bgtz;
    assign bgez     = dec_out.bgez;
    assign isb      = dec_out.isb;
    assign isj      = dec_out.isj;
    assign isjr     = dec_out.isjr;
    assign RegWrite = dec_out.reg_write;
    assign MemWrite = dec_out.mem_write;
    assign A3       = dec_out.a3;
    assign illegal  = dec_out.illegal;

endmodule

// File: tb/tb_decoder.sv
// Directed testbench for decoder. Works for both builds: each vector is
// driven on the falling edge and sampled 1 ns after the next rising edge,
// which covers zero latency and the one-cycle registered latency alike.
module tb_decoder;

    logic        clk;
    logic        reset;
    logic [31:0] IR;
    logic [1:0]  EXTop;
    logic        beq, bne, bltz, blez, bgtz, bgez;
    logic        isb, isj, isjr, RegWrite, MemWrite, illegal;
    logic [4:0]  A3;

    int total = 0;
    int bad   = 0;

    decoder dut (
        .clk      (clk),
        .reset    (reset),
        .IR       (IR),
        .EXTop    (EXTop),
        .beq      (beq),
        .bne      (bne),
        .bltz     (bltz),
        .blez     (blez),
        .bgtz     (bgtz),
        .bgez     (bgez),
        .isb      (isb),
        .isj      (isj),
        .isjr     (isjr),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .A3       (A3),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All outputs packed: {EXTop, beq,bne,bltz,blez,bgtz,bgez, isb,isj,isjr, RegWrite,MemWrite, A3, illegal}
    logic [18:0] obs;
    assign obs = {EXTop, beq, bne, bltz, blez, bgtz, bgez, isb, isj, isjr,
                  RegWrite, MemWrite, A3, illegal};

    function automatic logic [18:0] pk(input logic [1:0] ext, input logic [5:0] br,
                                       input logic b, input logic j, input logic jr,
                                       input logic rw, input logic mw,
                                       input logic [4:0] a3, input logic ill);
        return {ext, br, b, j, jr, rw, mw, a3, ill};
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [31:0] ir);
        @(negedge clk);
        IR = ir;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        IR    = 32'd0;
        #12;
        check("reset_state", obs, '0);
        @(negedge clk);
        reset = 1'b1;

        apply(32'h1022_0003);
        check("beq_vec", obs, pk(2'b01, 6'b100000, 1, 0, 0, 0, 0, 5'd0, 0));
        check("beq_flag", {18'd0, beq}, 19'd1);

        apply(32'h3C01_1234);
        check("lui_vec", obs, pk(2'b10, 6'b000000, 0, 0, 0, 1, 0, 5'd1, 0));

        apply(32'h0C00_0C00);
        check("jal_vec", obs, pk(2'b00, 6'b000000, 0, 1, 0, 1, 0, 5'd31, 0));

        apply(32'h0800_0C00);
        check("j_vec", obs, pk(2'b00, 6'b000000, 0, 1, 0, 0, 0, 5'd0, 0));

        apply(32'h0401_0002);
        check("bgez_vec", obs, pk(2'b01, 6'b000001, 1, 0, 0, 0, 0, 5'd0, 0));

        apply(32'h0402_0002);
        check("regimm_rt2_illegal", obs, pk(2'b00, 6'b000000, 0, 0, 0, 0, 0, 5'd0, 1));

        apply(32'h3422_0005);
        check("ori_vec", obs, pk(2'b00, 6'b000000, 0, 0, 0, 1, 0, 5'd2, 0));

        apply(32'h0022_1821);
        check("addu_vec", obs, pk(2'b00, 6'b000000, 0, 0, 0, 1, 0, 5'd3, 0));

        apply(32'h0000_0000);
        check("nop_vec", obs, '0);

        apply(32'h0022_1823);
        check("subu_vec", obs, pk(2'b00, 6'b000000, 0, 0, 0, 1, 0, 5'd3, 0));

        apply(32'h03E0_0008);
        check("jr_vec", obs, pk(2'b00, 6'b000000, 0, 0, 1, 0, 0, 5'd0, 0));

        apply(32'h2422_0007);
        check("addiu_vec", obs, pk(2'b01, 6'b000000, 0, 0, 0, 1, 0, 5'd2, 0));

        apply(32'h8C22_0004);
        check("lw_vec", obs, pk(2'b01, 6'b000000, 0, 0, 0, 1, 0, 5'd2, 0));

        apply(32'hAC22_0004);
        check("sw_vec", obs, pk(2'b01, 6'b000000, 0, 0, 0, 0, 1, 5'd0, 0));

        apply(32'h1422_0003);
        check("bne_vec", obs, pk(2'b01, 6'b010000, 1, 0, 0, 0, 0, 5'd0, 0));

        apply(32'h0400_0002);
        check("bltz_vec", obs, pk(2'b01, 6'b001000, 1, 0, 0, 0, 0, 5'd0, 0));

        apply(32'h1820_0003);
        check("blez_vec", obs, pk(2'b01, 6'b000100, 1, 0, 0, 0, 0, 5'd0, 0));

        apply(32'h1C20_0003);
        check("bgtz_vec", obs, pk(2'b01, 6'b000010, 1, 0, 0, 0, 0, 5'd0, 0));

        apply(32'h7C00_0000);
        check("bad_opcode", obs, pk(2'b00, 6'b000000, 0, 0, 0, 0, 0, 5'd0, 1));

        apply(32'h0022_1820);
        check("bad_funct", obs, pk(2'b00, 6'b000000, 0, 0, 0, 0, 0, 5'd0, 1));

        // Reset asserted mid-cycle with a lui on IR
        apply(32'h3C01_1234);
        #2;
        reset = 1'b0;
        #1;
`ifdef DECODER_PIPE_EN
        check("rst_async_clear", obs, '0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_hold_until_edge", obs, '0);
        @(posedge clk);
        #1;
        check("rst_release_lui", obs, pk(2'b10, 6'b000000, 0, 0, 0, 1, 0, 5'd1, 0));
`else
        check("rst_no_effect", obs, pk(2'b10, 6'b000000, 0, 0, 0, 1, 0, 5'd1, 0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_release_lui", obs, pk(2'b10, 6'b000000, 0, 0, 0, 1, 0, 5'd1, 0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
